// File: rtl/move_scheduler.sv
// move_scheduler: merges gravity drops and queued user moves
// into a single valid/ready command stream for the executioner.
module move_scheduler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         GRAVITY_DIV = 30000000,
    parameter logic [1:0] DOWN_CMD    = 2'd3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          gravity_en,
    input  logic                          flush,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_move,
    output logic [2:0]                    cmd_piece,
    output logic                          cmd_is_gravity,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int CW    = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state;
    logic [4:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   grav_cnt;
    logic            gravity_pending;
    logic            last_was_gravity;

    logic            push_req;
    logic            push_ok;
    logic            fifo_full;
    logic            fifo_empty;
    logic            grav_tick;
    logic            sel_gravity;
    logic            sel_fifo;
    logic [4:0]      fifo_head;
    logic            unused_rx_bits;

    assign unused_rx_bits = ^rx_data[7:6];

    // Push qualification, occupancy flags and source selection
    always_comb begin
        push_req    = rx_valid & rx_data[5];
        fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
        fifo_empty  = (fifo_count == '0);
        push_ok     = push_req & ~fifo_full;
        grav_tick   = gravity_en & (grav_cnt == CW'(GRAVITY_DIV - 1));
        fifo_head   = fifo_mem[rd_ptr];
        sel_gravity = (state == IDLE) & gravity_pending
                      & ~(last_was_gravity & ~fifo_empty);
        sel_fifo    = (state == IDLE) & ~fifo_empty & ~sel_gravity;
    end

    // FIFO storage; no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            fifo_mem[wr_ptr] <= rx_data[4:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (sel_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !sel_fifo) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && sel_fifo) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Sticky overflow, only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (!flush && push_req && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Gravity divider and single pending-tick flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grav_cnt        <= '0;
            gravity_pending <= 1'b0;
        end else if (flush) begin
            grav_cnt        <= '0;
            gravity_pending <= 1'b0;
        end else begin
            if (!gravity_en) begin
                grav_cnt <= '0;
            end else if (grav_tick) begin
                grav_cnt <= '0;
            end else begin
                grav_cnt <= grav_cnt + 1'b1;
            end
            if (sel_gravity) begin
                gravity_pending <= 1'b0;
            end else if (grav_tick) begin
                gravity_pending <= 1'b1;
            end
        end
    end

    // Issue FSM with registered command outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cmd_valid        <= 1'b0;
            cmd_move         <= 2'd0;
            cmd_piece        <= 3'd0;
            cmd_is_gravity   <= 1'b0;
            last_was_gravity <= 1'b0;
        end else if (flush) begin
            state            <= IDLE;
            cmd_valid        <= 1'b0;
            last_was_gravity <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_gravity) begin
                        cmd_move         <= DOWN_CMD;
                        cmd_piece        <= 3'd0;
                        cmd_is_gravity   <= 1'b1;
                        cmd_valid        <= 1'b1;
                        last_was_gravity <= 1'b1;
                        state            <= ISSUE;
                    end else if (sel_fifo) begin
                        cmd_move         <= fifo_head[1:0];
                        cmd_piece        <= fifo_head[4:2];
                        cmd_is_gravity   <= 1'b0;
                        cmd_valid        <= 1'b1;
                        last_was_gravity <= 1'b0;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed scenarios plus a randomized run
// compared against a queue-based model of the scheduler.
module tb_move_scheduler;

    localparam int DEPTH = 4;
    localparam int GDIV  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       gravity_en = 1'b0;
    logic       flush = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_move;
    logic [2:0] cmd_piece;
    logic       cmd_is_gravity;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int         q[$];
    bit         m_valid;
    logic [1:0] m_move;
    logic [2:0] m_piece;
    bit         m_grav;
    bit         m_ovf;
    bit         m_pending;
    bit         m_last;
    int         m_tcnt;

    always #5 clk = ~clk;

    move_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .GRAVITY_DIV(GDIV),
        .DOWN_CMD   (2'd3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .gravity_en    (gravity_en),
        .flush         (flush),
        .cmd_ready     (cmd_ready),
        .cmd_valid     (cmd_valid),
        .cmd_move      (cmd_move),
        .cmd_piece     (cmd_piece),
        .cmd_is_gravity(cmd_is_gravity),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    function automatic logic [7:0] mk(input int piece, input int move);
        logic [7:0] b;
        b = 8'h20;
        b[4:2] = 3'(piece);
        b[1:0] = 2'(move);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        m_move = 0;
        m_piece = 0;
        m_grav = 0;
        m_ovf = 0;
        m_pending = 0;
        m_last = 0;
        m_tcnt = 0;
    endtask

    // advances the model across the coming clock edge
    task automatic model_step();
        bit tick;
        bit load_g;
        bit load_f;
        bit was_full;
        int e;
        if (flush) begin
            q.delete();
            m_pending = 0;
            m_last = 0;
            m_tcnt = 0;
            m_valid = 0;
            return;
        end
        tick = gravity_en && (m_tcnt == GDIV - 1);
        m_tcnt = gravity_en ? (m_tcnt + 1) % GDIV : 0;
        was_full = (q.size() == DEPTH);
        load_g = 0;
        load_f = 0;
        if (m_valid) begin
            if (cmd_ready) m_valid = 0;
        end else if (m_pending && !(m_last && q.size() != 0)) begin
            load_g = 1;
        end else if (q.size() != 0) begin
            load_f = 1;
        end
        if (load_g) begin
            m_valid = 1;
            m_move = 2'd3;
            m_piece = 3'd0;
            m_grav = 1;
            m_last = 1;
            m_pending = 0;
        end else if (tick) begin
            m_pending = 1;
        end
        if (load_f) begin
            e = q.pop_front();
            m_valid = 1;
            m_move = e[1:0];
            m_piece = e[4:2];
            m_grav = 0;
            m_last = 0;
        end
        if (rx_valid && rx_data[5]) begin
            if (was_full) m_ovf = 1;
            else q.push_back(int'(rx_data[4:0]));
        end
    endtask

    task automatic do_reset();
        rx_valid = 0;
        rx_data = 0;
        gravity_en = 0;
        flush = 0;
        cmd_ready = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({cmd_valid, cmd_move, cmd_piece, cmd_is_gravity,
             fifo_count, overflow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b m=%0d p=%0d g=%b cnt=%0d ovf=%b want all 0",
                     cmd_valid, cmd_move, cmd_piece, cmd_is_gravity,
                     fifo_count, overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cmd_ready = 1;
        rx_valid = 1;
        rx_data = 8'h25;
        @(negedge clk);
        rx_valid = 0;
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL basic_push: got v=%b cnt=%0d want v=0 cnt=1",
                     cmd_valid, fifo_count);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_move !== 2'd1 ||
            cmd_piece !== 3'd1 || cmd_is_gravity !== 1'b0) begin
            failures++;
            $display("FAIL basic_issue: got v=%b m=%0d p=%0d g=%b want v=1 m=1 p=1 g=0",
                     cmd_valid, cmd_move, cmd_piece, cmd_is_gravity);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL basic_one_cycle: got v=%b cnt=%0d want v=0 cnt=0",
                     cmd_valid, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1;
            rx_data = mk(i, i % 4);
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (cmd_valid !== 1'b1 || cmd_move !== 2'd0 ||
                    cmd_piece !== 3'd0) begin
                    failures++;
                    $display("FAIL bp_hold_%0d: got v=%b m=%0d p=%0d want v=1 m=0 p=0",
                             i, cmd_valid, cmd_move, cmd_piece);
                end
            end
            if (i == 4) begin
                checks++;
                if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
                    failures++;
                    $display("FAIL bp_full: got ovf=%b cnt=%0d want ovf=0 cnt=4",
                             overflow, fifo_count);
                end
            end
        end
        rx_valid = 0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL bp_overflow: got ovf=%b cnt=%0d want ovf=1 cnt=4",
                     overflow, fifo_count);
        end
        cmd_ready = 1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (!cmd_valid && n < 6) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (cmd_valid !== 1'b1 || cmd_piece !== 3'(k) ||
                cmd_move !== 2'(k % 4)) begin
                failures++;
                $display("FAIL bp_drain_%0d: got v=%b m=%0d p=%0d want v=1 m=%0d p=%0d",
                         k, cmd_valid, cmd_move, cmd_piece, k % 4, k);
            end
            @(negedge clk);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_sticky: got ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_gravity();
        bit want;
        do_reset();
        gravity_en = 1;
        cmd_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            want = (c >= GDIV) && (c % GDIV == 0);
            checks++;
            if (cmd_valid !== want ||
                (want && (cmd_move !== 2'd3 || cmd_piece !== 3'd0 ||
                          cmd_is_gravity !== 1'b1))) begin
                failures++;
                $display("FAIL gravity_c%0d: got v=%b m=%0d p=%0d g=%b want v=%b m=3 p=0 g=1",
                         c, cmd_valid, cmd_move, cmd_piece, cmd_is_gravity, want);
            end
            rx_valid = 1;
            rx_data = 8'($urandom) & 8'hDF;
        end
        rx_valid = 0;
        checks++;
        if (fifo_count !== 3'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL gravity_nopush: got cnt=%0d ovf=%b want 0 0",
                     fifo_count, overflow);
        end
    endtask

    task automatic test_fairness();
        int exp_piece[5] = '{1, 0, 2, 3, 4};
        bit exp_grav[5]  = '{0, 1, 0, 0, 0};
        int n;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1;
            rx_data = mk(i, 1);
            @(negedge clk);
        end
        rx_valid = 0;
        gravity_en = 1;
        repeat (GDIV) @(negedge clk);
        gravity_en = 0;
        checks++;
        if (fifo_count !== 3'd3 || cmd_piece !== 3'd1) begin
            failures++;
            $display("FAIL fair_setup: got cnt=%0d p=%0d want cnt=3 p=1",
                     fifo_count, cmd_piece);
        end
        cmd_ready = 1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!cmd_valid && n < 6) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (cmd_valid !== 1'b1 || cmd_piece !== 3'(exp_piece[k]) ||
                cmd_is_gravity !== exp_grav[k]) begin
                failures++;
                $display("FAIL fair_order_%0d: got v=%b p=%0d g=%b want v=1 p=%0d g=%b",
                         k, cmd_valid, cmd_piece, cmd_is_gravity,
                         exp_piece[k], exp_grav[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            rx_valid = 1;
            rx_data = mk(i, 2);
            @(negedge clk);
        end
        rx_valid = 0;
        checks++;
        if (cmd_valid !== 1'b1 || fifo_count !== 3'd4 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: got v=%b cnt=%0d ovf=%b want 1 4 1",
                     cmd_valid, fifo_count, overflow);
        end
        flush = 1;
        rx_valid = 1;
        rx_data = mk(6, 1);
        @(negedge clk);
        flush = 0;
        rx_valid = 0;
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: got v=%b cnt=%0d ovf=%b want 0 0 1",
                     cmd_valid, fifo_count, overflow);
        end
        cmd_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_quiet_%0d: got v=%b want 0", c, cmd_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rx_valid = 1;
        rx_data = 8'h36;
        @(negedge clk);
        rx_data = 8'h2B;
        @(negedge clk);
        rx_valid = 0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_move !== 2'd2 || cmd_piece !== 3'd5 ||
            fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL rstmid_setup: got v=%b m=%0d p=%0d cnt=%0d want 1 2 5 1",
                     cmd_valid, cmd_move, cmd_piece, fifo_count);
        end
        reset = 1;
        #1;
        checks++;
        if ({cmd_valid, cmd_move, cmd_piece, cmd_is_gravity,
             fifo_count, overflow} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_async: got v=%b m=%0d p=%0d g=%b cnt=%0d ovf=%b want all 0",
                     cmd_valid, cmd_move, cmd_piece, cmd_is_gravity,
                     fifo_count, overflow);
        end
        @(negedge clk);
        reset = 0;
        cmd_ready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_gone_%0d: got v=%b want 0", c, cmd_valid);
            end
        end
    endtask

    task automatic test_random();
        int shown;
        bit bad;
        shown = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            bad = (cmd_valid !== m_valid) ||
                  (int'(fifo_count) != q.size()) ||
                  (overflow !== m_ovf) ||
                  (m_valid && (cmd_move !== m_move ||
                               cmd_piece !== m_piece ||
                               cmd_is_gravity !== m_grav));
            if (bad) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_c%0d: got v=%b m=%0d p=%0d g=%b cnt=%0d ovf=%b want v=%b m=%0d p=%0d g=%b cnt=%0d ovf=%b",
                             c, cmd_valid, cmd_move, cmd_piece, cmd_is_gravity,
                             fifo_count, overflow, m_valid, m_move, m_piece,
                             m_grav, q.size(), m_ovf);
                end
            end
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            cmd_ready = ((c / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 3) != 0);
            gravity_en = ($urandom_range(0, 15) != 0);
            flush = ($urandom_range(0, 63) == 0);
            model_step();
            @(negedge clk);
        end
        flush = 0;
        rx_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_gravity();
        test_fairness();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
